cpu_fetch: RTL and testbench

Instruction fetch and predecode stage for the NES 6502 core. It sits directly upstream of the `cpu` controller FSM. After reset it loads the program counter from the reset vector. It then fetches the opcode byte and computes instruction length from the `aaa/bbb/cc` fields. It gathers 0–2 operand bytes and hands the assembled instruction to the controller over a valid/ready handshake. The controller can redirect the fetch stream (jumps, branches, interrupts) at any time.

---
 rtl/cpu_fetch.sv | 172 +++++++++++++++++
 tb/tb_cpu_fetch.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_fetch.sv
// cpu_fetch: 6502 instruction fetch and predecode stage.
// After reset it loads the PC from the reset vector, then fetches the opcode and
// 0-2 operand bytes and presents the assembled bundle over a valid/ready handshake.
// addr/rd are registered: the address for a state is set on the edge entering it,
// and d_in (the byte at the current addr) is captured on the edge leaving it.
module cpu_fetch #(
  parameter logic [15:0] RESET_VECTOR = 16'hFFFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  d_in,
  output logic [15:0] addr,
  output logic        rd,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [7:0]  opcode,
  output logic [15:0] operand,
  output logic [1:0]  len,
  output logic [15:0] op_pc
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;

  typedef enum logic [2:0] {
    VEC0, VEC1, VEC2, OP, B0, B1, B2, OUT
  } state_t;

  state_t        state;
  logic [AW-1:0] pc;
  logic [1:0]    dec_len;

  // Instruction length from the aaa/bbb/cc fields of an opcode byte.
  function automatic logic [1:0] len_decode(input logic [DW-1:0] op);
    logic [2:0] bbb;
    logic [1:0] cc;
    logic [1:0] l;
    bbb = op[4:2];
    cc  = op[1:0];
    l   = 2'd1;
    if (op == 8'h20) begin
      l = 2'd3;
    end else if (op == 8'h00 || op == 8'h40 || op == 8'h60) begin
      l = 2'd1;
    end else if (cc == 2'b01) begin
      l = (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) ? 2'd3 : 2'd2;
    end else if (cc == 2'b11) begin
      l = 2'd1;
    end else begin
      case (bbb)
        3'b000:  l = 2'd2;
        3'b001:  l = 2'd2;
        3'b010:  l = 2'd1;
        3'b011:  l = 2'd3;
        3'b100:  l = (cc == 2'b00) ? 2'd2 : 2'd1;
        3'b101:  l = 2'd2;
        3'b110:  l = 2'd1;
        default: l = 2'd3;
      endcase
    end
    return l;
  endfunction

  // Predecode of the byte currently on the read bus.
  always_comb begin
    dec_len = len_decode(d_in);
  end

  // Fetch FSM with registered memory interface and bundle outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= VEC0;
      pc        <= '0;
      addr      <= RESET_VECTOR;
      rd        <= 1'b0;
      ins_valid <= 1'b0;
      opcode    <= '0;
      operand   <= '0;
      len       <= '0;
      op_pc     <= '0;
    end else begin
      case (state)
        VEC0: begin
          addr  <= RESET_VECTOR;
          rd    <= 1'b1;
          state <= VEC1;
        end
        VEC1: begin
          pc[7:0] <= d_in;
          addr    <= RESET_VECTOR + 16'd1;
          rd      <= 1'b1;
          state   <= VEC2;
        end
        VEC2: begin
          pc      <= {d_in, pc[7:0]};
          addr    <= {d_in, pc[7:0]};
          rd      <= 1'b1;
          operand <= '0;
          state   <= OP;
        end
        default: begin
          if (redirect) begin
            // Redirect wins over every other transition; partial fetch is dropped.
            pc        <= redirect_pc;
            addr      <= redirect_pc;
            rd        <= 1'b1;
            ins_valid <= 1'b0;
            operand   <= '0;
            state     <= OP;
          end else begin
            case (state)
              OP: begin
                addr  <= pc;
                rd    <= 1'b1;
                op_pc <= pc;
                pc    <= pc + 16'd1;
                state <= B0;
              end
              B0: begin
                opcode <= d_in;
                len    <= dec_len;
                if (dec_len >= 2'd2) begin
                  addr  <= pc;
                  rd    <= 1'b1;
                  pc    <= pc + 16'd1;
                  state <= B1;
                end else begin
                  rd        <= 1'b0;
                  ins_valid <= 1'b1;
                  state     <= OUT;
                end
              end
              B1: begin
                operand[7:0] <= d_in;
                if (len == 2'd3) begin
                  addr  <= pc;
                  rd    <= 1'b1;
                  pc    <= pc + 16'd1;
                  state <= B2;
                end else begin
                  rd        <= 1'b0;
                  ins_valid <= 1'b1;
                  state     <= OUT;
                end
              end
              B2: begin
                operand[15:8] <= d_in;
                rd            <= 1'b0;
                ins_valid     <= 1'b1;
                state         <= OUT;
              end
              OUT: begin
                if (ins_ready) begin
                  ins_valid <= 1'b0;
                  addr      <= pc;
                  rd        <= 1'b1;
                  operand   <= '0;
                  state     <= OP;
                end
              end
              default: begin
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_fetch.sv
// Directed testbench for cpu_fetch with a behavioural memory returning the
// byte at the current read address.
module tb_cpu_fetch;

  logic        clk;
  logic        rst;
  logic [7:0]  d_in;
  logic [15:0] addr;
  logic        rd;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        ins_valid;
  logic        ins_ready;
  logic [7:0]  opcode;
  logic [15:0] operand;
  logic [1:0]  len;
  logic [15:0] op_pc;

  logic [7:0] mem [0:65535];
  int checks;
  int failures;

  cpu_fetch #(.RESET_VECTOR(16'hFFFC)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .addr(addr), .rd(rd),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .ins_valid(ins_valid), .ins_ready(ins_ready),
    .opcode(opcode), .operand(operand), .len(len), .op_pc(op_pc)
  );

  assign d_in = mem[addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Wait up to max cycles for ins_valid; n is the number of edges waited.
  task automatic wait_valid(input int max, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < max && !ok) begin
      @(posedge clk); #1;
      n++;
      if (ins_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000; ins_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (addr !== 16'hFFFC || rd !== 1'b0) begin failures++; $display("FAIL reset_bus: addr=%h rd=%b want FFFC 0", addr, rd); end
    checks++; if (ins_valid !== 1'b0 || opcode !== 8'h00 || operand !== 16'h0000 || len !== 2'd0 || op_pc !== 16'h0000) begin
      failures++; $display("FAIL reset_bundle: v=%b op=%h opr=%h len=%0d pc=%h want all 0", ins_valid, opcode, operand, len, op_pc); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (addr !== 16'hFFFC || rd !== 1'b1) begin failures++; $display("FAIL vec_lo: addr=%h rd=%b want FFFC 1", addr, rd); end
    @(posedge clk); #1;
    checks++; if (addr !== 16'hFFFD || rd !== 1'b1) begin failures++; $display("FAIL vec_hi: addr=%h rd=%b want FFFD 1", addr, rd); end
    @(posedge clk); #1;
    checks++; if (addr !== 16'h8000 || rd !== 1'b1) begin failures++; $display("FAIL first_op: addr=%h rd=%b want 8000 1", addr, rd); end
  endtask

  task automatic test_mixed();
    int n; bit ok;
    ins_ready = 1'b1;
    wait_valid(10, n, ok);
    checks++; if (!ok || n != 2) begin failures++; $display("FAIL lat1: ok=%b cycles=%0d want 2", ok, n); end
    checks++; if (opcode !== 8'hEA || len !== 2'd1 || op_pc !== 16'h8000 || operand !== 16'h0000) begin
      failures++; $display("FAIL bundle1: op=%h len=%0d pc=%h opr=%h want EA 1 8000 0000", opcode, len, op_pc, operand); end
    wait_valid(10, n, ok);
    checks++; if (!ok || n != 4) begin failures++; $display("FAIL lat2: ok=%b cycles=%0d want 4", ok, n); end
    checks++; if (opcode !== 8'hA9 || len !== 2'd2 || op_pc !== 16'h8001 || operand !== 16'h0042) begin
      failures++; $display("FAIL bundle2: op=%h len=%0d pc=%h opr=%h want A9 2 8001 0042", opcode, len, op_pc, operand); end
  endtask

  task automatic test_backpressure();
    int n; bit ok;
    @(posedge clk); #1;
    ins_ready = 1'b0;
    wait_valid(10, n, ok);
    checks++; if (!ok || n != 4) begin failures++; $display("FAIL lat3: ok=%b cycles=%0d want 4", ok, n); end
    checks++; if (opcode !== 8'hAD || len !== 2'd3 || op_pc !== 16'h8003 || operand !== 16'h1234) begin
      failures++; $display("FAIL bundle3: op=%h len=%0d pc=%h opr=%h want AD 3 8003 1234", opcode, len, op_pc, operand); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (ins_valid !== 1'b1 || opcode !== 8'hAD || operand !== 16'h1234 || len !== 2'd3 || op_pc !== 16'h8003 || rd !== 1'b0 || addr !== 16'h8005) begin
        failures++; $display("FAIL stall_%0d: v=%b op=%h opr=%h len=%0d pc=%h rd=%b addr=%h", i, ins_valid, opcode, operand, len, op_pc, rd, addr); end
    end
    ins_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (ins_valid !== 1'b0 || addr !== 16'h8006 || rd !== 1'b1) begin
      failures++; $display("FAIL after_stall: v=%b addr=%h rd=%b want 0 8006 1", ins_valid, addr, rd); end
  endtask

  task automatic test_back_to_back();
    int n; bit ok;
    wait_valid(10, n, ok);
    checks++; if (!ok || n != 2 || op_pc !== 16'h8006 || opcode !== 8'hEA) begin
      failures++; $display("FAIL b2b_first: ok=%b cycles=%0d pc=%h op=%h want 2 8006 EA", ok, n, op_pc, opcode); end
    wait_valid(10, n, ok);
    checks++; if (!ok || n != 3 || op_pc !== 16'h8007) begin
      failures++; $display("FAIL b2b_period: ok=%b cycles=%0d pc=%h want 3 8007", ok, n, op_pc); end
  endtask

  task automatic test_redirect_b1();
    int n; bit ok;
    @(posedge clk); #1;
    checks++; if (addr !== 16'h8008) begin failures++; $display("FAIL rd_op_addr: addr=%h want 8008", addr); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (addr !== 16'h8009 || rd !== 1'b1) begin failures++; $display("FAIL rd_b1_addr: addr=%h rd=%b want 8009 1", addr, rd); end
    redirect = 1'b1; redirect_pc = 16'hC000;
    @(posedge clk); #1;
    redirect = 1'b0;
    checks++; if (ins_valid !== 1'b0 || addr !== 16'hC000 || rd !== 1'b1) begin
      failures++; $display("FAIL redirect_b1: v=%b addr=%h rd=%b want 0 C000 1", ins_valid, addr, rd); end
    wait_valid(10, n, ok);
    checks++; if (!ok || n != 2 || op_pc !== 16'hC000 || opcode !== 8'hEA || operand !== 16'h0000) begin
      failures++; $display("FAIL redirect_bundle: ok=%b cycles=%0d pc=%h op=%h opr=%h want 2 C000 EA 0000", ok, n, op_pc, opcode, operand); end
  endtask

  task automatic test_redirect_accept();
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    @(posedge clk); #1;
    redirect = 1'b0;
    checks++; if (ins_valid !== 1'b0 || addr !== 16'hFFFE || rd !== 1'b1) begin
      failures++; $display("FAIL redirect_out: v=%b addr=%h rd=%b want 0 FFFE 1", ins_valid, addr, rd); end
  endtask

  task automatic test_wrap();
    int n; bit ok;
    wait_valid(10, n, ok);
    checks++; if (!ok || n != 4 || opcode !== 8'h4C || len !== 2'd3 || op_pc !== 16'hFFFE || operand !== 16'h0000) begin
      failures++; $display("FAIL wrap_bundle: ok=%b cycles=%0d op=%h len=%0d pc=%h opr=%h want 4 4C 3 FFFE 0000", ok, n, opcode, len, op_pc, operand); end
    @(posedge clk); #1;
    checks++; if (addr !== 16'h0001 || rd !== 1'b1) begin failures++; $display("FAIL wrap_next: addr=%h rd=%b want 0001 1", addr, rd); end
  endtask

  task automatic test_async_reset();
    ins_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (addr !== 16'h0003 || rd !== 1'b1) begin failures++; $display("FAIL pre_reset_b2: addr=%h rd=%b want 0003 1", addr, rd); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (ins_valid !== 1'b0 || rd !== 1'b0 || addr !== 16'hFFFC || opcode !== 8'h00 || op_pc !== 16'h0000 || len !== 2'd0) begin
      failures++; $display("FAIL async_reset: v=%b rd=%b addr=%h op=%h pc=%h len=%0d want 0 0 FFFC 00 0000 0", ins_valid, rd, addr, opcode, op_pc, len); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (addr !== 16'hFFFC || rd !== 1'b1) begin failures++; $display("FAIL restart_lo: addr=%h rd=%b want FFFC 1", addr, rd); end
    @(posedge clk); #1;
    checks++; if (addr !== 16'hFFFD || rd !== 1'b1) begin failures++; $display("FAIL restart_hi: addr=%h rd=%b want FFFD 1", addr, rd); end
    @(posedge clk); #1;
    checks++; if (addr !== 16'h8000 || rd !== 1'b1) begin failures++; $display("FAIL restart_op: addr=%h rd=%b want 8000 1", addr, rd); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000; ins_ready = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
    mem[16'h8000] = 8'hEA;
    mem[16'h8001] = 8'hA9; mem[16'h8002] = 8'h42;
    mem[16'h8003] = 8'hAD; mem[16'h8004] = 8'h34; mem[16'h8005] = 8'h12;
    mem[16'h8008] = 8'hA9; mem[16'h8009] = 8'h55;
    mem[16'hFFFE] = 8'h4C; mem[16'hFFFF] = 8'h00; mem[16'h0000] = 8'h00;
    mem[16'h0001] = 8'hAD; mem[16'h0002] = 8'h11; mem[16'h0003] = 8'h22;

    test_reset();
    test_mixed();
    test_backpressure();
    test_back_to_back();
    test_redirect_b1();
    test_redirect_accept();
    test_wrap();
    test_async_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
